uart_rx_ovs: RTL
================

// Module: uart_rx_ovs
// PURPOSE
//  Parametrised UART receiver: 16x-oversampled, majority-voted, with configurable data bits, parity and stop bits.
//  Validates the start bit, checks parity and stop bits, then presents each received word with a one-cycle wr strobe.
//  Supplies a wrapping wr_addr for the pulse-parameter memory. Host-link front end of the pulse generator.
// PARAMETERS
//  FCLK       100000000  input clock frequency [Hz]
//  BAUD       9600       line rate [bit/s]
//  OVS        16         oversampling factor; even, >=8
//  DATA_BITS  8          data bits per frame, 5..9
//  PARITY     0          0 none, 1 odd, 2 even
//  STOP_BITS  1          1 or 2
//  ADDR_W     3          width of wr_addr
// PORTS
//  clk_Rx      in   1          system clock
//  rst_n       in   1          asynchronous active-low reset
//  Rx_in       in   1          serial line, idle high, asynchronous to clk_Rx
//  data_out    out  DATA_BITS  last received word; bit 0 is the first data bit on the line
//  wr          out  1          one-cycle strobe: data_out, wr_addr and error flags valid
//  wr_addr     out  ADDR_W     write address for the current word
//  parity_err  out  1          parity mismatch in the current word (always 0 when PARITY=0)
//  frame_err   out  1          a stop bit sampled low in the current word
//  busy        out  1          high from start-bit detection until return to IDLE
// BEHAVIOUR
//  Reset values (async, rst_n=0): all outputs 0; FSM IDLE; all counters 0; both synchroniser flops 1.
//  Sync: Rx_in passes through 2 flops (rx_s); all logic below uses rx_s only.
//  Tick: DIV = FCLK/(BAUD*OVS)-1 on a 16-bit counter; tick is one clk_Rx cycle when count==DIV, then count reloads to 0.
//  Sampling: a sub-bit counter runs 0..OVS-1 on ticks. Bit value = majority of rx_s at sub-counts OVS/2-1, OVS/2, OVS/2+1.
//  FSM:
//   IDLE   : on the first tick with rx_s=0 -> START; sub-counter cleared; busy=1.
//   START  : decide at sub=OVS/2+1. Vote 1 -> IDLE (glitch; no wr, no flags).
//            Vote 0 -> DATA; DATA sampling starts OVS ticks later.
//   DATA   : DATA_BITS bits, LSB first, shifted into a holding register. After the last bit -> PARITY if PARITY!=0, else STOP.
//   PARITY : perr = XOR(data, parity bit) ^ (PARITY==1).
//   STOP   : STOP_BITS bits. ferr = OR of (stop vote==0). After the last stop decision -> DONE.
//   DONE   : one cycle. wr=1; data_out<=holding reg; parity_err<=perr; frame_err<=ferr.
//            Then -> IDLE if rx_s=1, else -> BREAK.
//   BREAK  : wait for rx_s=1 for one full tick, then -> IDLE. Line break / stuck-low gives exactly one wr.
//  Latency: wr rises 1 clk_Rx cycle after the last stop-bit vote (≈ mid last stop bit). Early stop decision allows back-to-back frames.
//  Held outputs: data_out, parity_err and frame_err hold until the next DONE. Words with errors are still written (wr=1) and advance wr_addr.
//  wr_addr: wr_addr is the address of the current word. It increments by 1 in the cycle after wr; 2^ADDR_W-1 -> 0 (natural wrap).
//  busy: 1 in START/DATA/PARITY/STOP/DONE/BREAK, 0 in IDLE.
//  Reset mid-frame: frame is discarded, no wr; next frame is received normally after release.
//  Arithmetic: bit counter width clog2(DATA_BITS+1); sub-counter width clog2(OVS); all counters wrap only as described.
// TESTING (bench params FCLK=1600000, BAUD=100000, OVS=16 -> DIV=0, 16 clk/bit)
//  8N1 0xA5, then 0x3C back-to-back.
//    -> two wr pulses; data_out=0xA5 then 0x3C; wr_addr=0 then 1; flags 0.
//  Glitch: Rx_in low for 5 clk, then high.
//    -> START aborts to IDLE; no wr; busy drops within 17 clk.
//  PARITY=2, 0x07 with parity bit 1 -> wr, parity_err=0.
//    Same data, parity bit 0 -> parity_err=1.
//  0x81 with stop bit 0, line then high.
//    -> wr, data_out=0x81, frame_err=1.
//    Next good frame -> frame_err=0.
//  Break: Rx_in held low 40 bit-times -> exactly one wr (data 0x00, frame_err=1); no further wr until line high.
//  Wrap and reset: 9 frames, wr_addr sequence 0..7,0.
//    rst_n pulsed low mid-DATA -> outputs 0, no wr; following 0x5A received at wr_addr=0.

Source files
------------

// File: rtl/uart_rx_ovs_if.sv
// rtl/uart_rx_ovs_if.sv - serial input and received-word output bundle of uart_rx_ovs
interface uart_rx_ovs_if #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_W    = 3
);
  logic                 rx_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 wr;
  logic [ADDR_W-1:0]    wr_addr;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  rx_in,
    output data_out, wr, wr_addr, parity_err, frame_err, busy
  );

  modport slave (
    output rx_in,
    input  data_out, wr, wr_addr, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_ovs.sv
// rtl/uart_rx_ovs.sv - 16x-oversampled majority-voting UART receiver with wrapping write address
module uart_rx_ovs #(
  parameter int FCLK      = 100000000,
  parameter int BAUD      = 9600,
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int ADDR_W    = 3
) (
  input  logic           i_clk_Rx,
  input  logic           i_rst_n,
  uart_rx_ovs_if.master  io
);

  localparam int SUB_W = $clog2(OVS);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam int DIV   = FCLK / (BAUD * OVS) - 1;

  localparam logic [15:0]      DIV16     = 16'(DIV);
  localparam logic [SUB_W-1:0] SUB_A     = SUB_W'(OVS / 2 - 1);
  localparam logic [SUB_W-1:0] SUB_B     = SUB_W'(OVS / 2);
  localparam logic [SUB_W-1:0] SUB_C     = SUB_W'(OVS / 2 + 1);
  localparam logic [SUB_W-1:0] SUB_L     = SUB_W'(OVS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_BREAK
  } state_t;

  state_t r_state, w_state_nx;

  logic                 r_rx_m, r_rx_s;
  logic [15:0]          r_div;
  logic [SUB_W-1:0]     r_sub;
  logic [1:0]           r_samp;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr, r_ferr;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_parity_err, r_frame_err;
  logic [ADDR_W-1:0]    r_wr_addr;

  logic w_tick, w_sampling, w_decide, w_vote, w_ld_out;

  assign w_tick     = (r_div == DIV16);
  assign w_sampling = (r_state == S_START) || (r_state == S_DATA) ||
                      (r_state == S_PARITY) || (r_state == S_STOP);
  assign w_decide   = w_tick && w_sampling && (r_sub == SUB_C);
  // Third sample is taken live at the decision tick.
  assign w_vote     = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_rx_s) | (r_samp[1] & r_rx_s);
  assign w_ld_out   = (r_state == S_STOP) && (w_state_nx == S_DONE);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (w_tick && !r_rx_s) w_state_nx = S_START;
      S_START:  if (w_decide) w_state_nx = w_vote ? S_IDLE : S_DATA;
      S_DATA:   if (w_decide && r_bit == BIT_LAST)
                  w_state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_decide) w_state_nx = S_STOP;
      S_STOP:   if (w_decide && r_bit == STOP_LAST) w_state_nx = S_DONE;
      S_DONE:   w_state_nx = r_rx_s ? S_IDLE : S_BREAK;
      S_BREAK:  if (w_tick && r_rx_s) w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_Rx or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge i_clk_Rx or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_m       <= 1'b1;
      r_rx_s       <= 1'b1;
      r_div        <= '0;
      r_sub        <= '0;
      r_samp       <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_data_out   <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_wr_addr    <= '0;
    end else begin
      r_rx_m <= io.rx_in;
      r_rx_s <= r_rx_m;
      r_div  <= w_tick ? 16'd0 : r_div + 16'd1;

      // Sub-counter free-runs mod OVS through the frame so each bit decision lands OVS ticks apart.
      if (r_state == S_IDLE) begin
        r_sub <= '0;
      end else if (w_tick) begin
        r_sub <= (r_sub == SUB_L) ? '0 : r_sub + 1'b1;
        if (r_sub == SUB_A) r_samp[0] <= r_rx_s;
        if (r_sub == SUB_B) r_samp[1] <= r_rx_s;
      end

      if (r_state != S_DATA && r_state != S_STOP) begin
        r_bit <= '0;
      end else if (w_decide) begin
        r_bit <= (w_state_nx != r_state) ? '0 : r_bit + 1'b1;
      end

      if (r_state == S_START) begin
        r_perr <= 1'b0;
        r_ferr <= 1'b0;
      end
      if (w_decide && r_state == S_DATA)   r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
      if (w_decide && r_state == S_PARITY) r_perr  <= (^r_shift) ^ w_vote ^ PAR_ODD;
      if (w_decide && r_state == S_STOP)   r_ferr  <= r_ferr | ~w_vote;

      if (w_ld_out) begin
        r_data_out   <= r_shift;
        r_parity_err <= r_perr;
        r_frame_err  <= r_ferr | ~w_vote;
      end

      if (r_state == S_DONE) r_wr_addr <= r_wr_addr + 1'b1;
    end
  end

  assign io.data_out   = r_data_out;
  assign io.parity_err = r_parity_err;
  assign io.frame_err  = r_frame_err;
  assign io.wr_addr    = r_wr_addr;
  assign io.wr         = (r_state == S_DONE);
  assign io.busy       = (r_state != S_IDLE);

endmodule
